// File: rtl/pwm_pkg.sv
// Shared constants and types for the pwm_generator tile.
package pwm_pkg;

  localparam int unsigned CNT_W = 12;

  // Bit positions within the Tiny Tapeout pin buses.
  localparam int unsigned SEL_BIT  = 6;
  localparam int unsigned WREN_BIT = 7;
  localparam int unsigned PWM_BIT  = 0;
  localparam int unsigned PWMN_BIT = 1;
  localparam int unsigned CYC_BIT  = 2;

  typedef enum logic {
    SEL_DUTY   = 1'b0,
    SEL_PERIOD = 1'b1
  } reg_sel_e;

endpackage

// File: rtl/pwm_core.sv
// Free-running period counter with registered duty compare and cycle-start pulse.
module pwm_core
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] period,
  output logic             pwm,
  output logic             cyc_start,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_m1;
  logic             pwm_q, pwm_d;
  logic             cyc_q, cyc_d;
  logic             running;

  assign running   = (period != '0);
  assign period_m1 = period - CNT_W'(1);
  // >= rather than == so a shrinking period wraps at once instead of overrunning.
  assign wrap      = running && (cnt_q >= period_m1);

  always_comb begin
    cnt_d = cnt_q;
    pwm_d = 1'b0;
    cyc_d = 1'b0;
    if (!running) begin
      cnt_d = '0;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      pwm_d = (cnt_q < duty);
      cyc_d = (cnt_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
      cyc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      cyc_q <= cyc_d;
    end
  end

  assign pwm       = pwm_q;
  assign cyc_start = cyc_q;

endmodule

// File: rtl/pwm_generator.sv
// Tiny Tapeout 12-bit PWM tile: register file, pin mapping and pwm_core.
// Define PWM_SHADOW_UPDATE_EN to defer duty/period writes to the period boundary.
module pwm_generator
  import pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [CNT_W-1:0] data;
  reg_sel_e         sel;
  logic             wr_en;
  logic             wr_duty;
  logic             wr_period;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] period_q;
  logic             pwm;
  logic             cyc_start;
  logic             wrap;
  logic             unused_bits;

  assign data      = {uio_in[3:0], ui_in};
  assign sel       = reg_sel_e'(uio_in[SEL_BIT]);
  assign wr_en     = uio_in[WREN_BIT];
  assign wr_duty   = wr_en && (sel == SEL_DUTY);
  assign wr_period = wr_en && (sel == SEL_PERIOD);

`ifdef PWM_SHADOW_UPDATE_EN
  logic [CNT_W-1:0] shadow_duty_q;
  logic [CNT_W-1:0] shadow_period_q;
  logic             load;

  // An idle counter (P==0) has no boundary to wait for, so it follows the shadows directly.
  assign load = wrap || (period_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_duty_q   <= '0;
      shadow_period_q <= '0;
      duty_q          <= '0;
      period_q        <= '0;
    end else begin
      if (wr_duty)   shadow_duty_q   <= data;
      if (wr_period) shadow_period_q <= data;
      if (load) begin
        duty_q   <= shadow_duty_q;
        period_q <= shadow_period_q;
      end
    end
  end

  assign unused_bits = ^{ena, uio_in[5:4]};
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q   <= '0;
      period_q <= '0;
    end else begin
      if (wr_duty)   duty_q   <= data;
      if (wr_period) period_q <= data;
    end
  end

  assign unused_bits = ^{ena, uio_in[5:4], wrap};
`endif

  pwm_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .duty      (duty_q),
    .period    (period_q),
    .pwm       (pwm),
    .cyc_start (cyc_start),
    .wrap      (wrap)
  );

  always_comb begin
    uo_out           = '0;
    uo_out[PWM_BIT]  = pwm;
    uo_out[PWMN_BIT] = ~pwm;
    uo_out[CYC_BIT]  = cyc_start;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: table of period/duty vectors plus corner sequences.
module tb_pwm_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_generator dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int duty;
    int exp_highs;  // pwm high samples over a window of 4 periods (40 cycles if P==0)
    int exp_cycs;   // cyc_start pulses over the same window
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic sel, input int val);
    logic [11:0] d;
    d = 12'(val);
    @(negedge clk);
    ui_in  = d[7:0];
    uio_in = {1'b1, sel, 2'b00, d[11:8]};
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  // Returns number of negedges until cyc_start is seen, or -1 if the bound expires.
  task automatic wait_cyc(input int bound, output int waited);
    waited = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (uo_out[2]) begin
        waited = i;
        break;
      end
    end
  endtask

  vec_t vecs[9];

  initial begin
    int highs, cycs, last, bad_gap, bad_align, bad_aux, win, w, cyc_pos;

    vecs[0] = '{period: 10, duty: 3,    exp_highs: 12,  exp_cycs: 4};
    vecs[1] = '{period: 8,  duty: 0,    exp_highs: 0,   exp_cycs: 4};
    vecs[2] = '{period: 8,  duty: 8,    exp_highs: 32,  exp_cycs: 4};
    vecs[3] = '{period: 8,  duty: 4095, exp_highs: 32,  exp_cycs: 4};
    vecs[4] = '{period: 1,  duty: 1,    exp_highs: 4,   exp_cycs: 4};
    vecs[5] = '{period: 0,  duty: 5,    exp_highs: 0,   exp_cycs: 0};
    vecs[6] = '{period: 5,  duty: 2,    exp_highs: 8,   exp_cycs: 4};
    vecs[7] = '{period: 3,  duty: 1,    exp_highs: 4,   exp_cycs: 4};
    vecs[8] = '{period: 100, duty: 50,  exp_highs: 200, exp_cycs: 4};

    // Reset state, no writes.
    do_reset();
    check("reset uo_out", int'(uo_out), 2);
    check("reset uio_oe", int'(uio_oe), 0);
    check("reset uio_out", int'(uio_out), 0);
    highs = 0;
    cycs  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uo_out[0]) highs++;
      if (uo_out[2]) cycs++;
    end
    check("idle pwm highs", highs, 0);
    check("idle cyc pulses", cycs, 0);

    // Table-driven steady-state vectors.
    for (int k = 0; k < 9; k++) begin
      do_reset();
      wr(1'b1, vecs[k].period);
      wr(1'b0, vecs[k].duty);
      repeat (2 * vecs[k].period + 6) @(negedge clk);
      win       = (vecs[k].period == 0) ? 40 : 4 * vecs[k].period;
      highs     = 0;
      cycs      = 0;
      last      = -1;
      bad_gap   = 0;
      bad_align = 0;
      bad_aux   = 0;
      for (int i = 0; i < win; i++) begin
        @(negedge clk);
        if (uo_out[1] !== ~uo_out[0] || uo_out[7:3] !== 5'b0 || uio_oe !== 8'h00) bad_aux++;
        if (uo_out[0]) highs++;
        if (uo_out[2]) begin
          cycs++;
          if (last >= 0 && (i - last) != vecs[k].period) bad_gap++;
          last = i;
          if (uo_out[0] !== (vecs[k].duty != 0)) bad_align++;
        end
      end
      check($sformatf("v%0d P=%0d D=%0d highs", k, vecs[k].period, vecs[k].duty),
            highs, vecs[k].exp_highs);
      check($sformatf("v%0d cyc count", k), cycs, vecs[k].exp_cycs);
      check($sformatf("v%0d cyc spacing", k), bad_gap, 0);
      check($sformatf("v%0d cyc/pwm align", k), bad_align, 0);
      check($sformatf("v%0d pwm_n/unused pins", k), bad_aux, 0);
    end

    // period=1 duty=1, then period=0: output drops and pulses stop within 2 clocks.
    do_reset();
    wr(1'b1, 1);
    wr(1'b0, 1);
    repeat (6) @(negedge clk);
    check("p1 pwm high", int'(uo_out[0]), 1);
    check("p1 cyc high", int'(uo_out[2]), 1);
    ui_in  = 8'h00;
    uio_in = 8'hC0;
    @(negedge clk);
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    highs = 0;
    cycs  = 0;
    for (int i = 0; i < 10; i++) begin
      if (uo_out[0]) highs++;
      if (uo_out[2]) cycs++;
      @(negedge clk);
    end
    check("p0 pwm highs", highs, 0);
    check("p0 cyc pulses", cycs, 0);

    // Shrink period mid-run: 100 -> 20 written when cnt is 80.
    do_reset();
    wr(1'b1, 100);
    wr(1'b0, 50);
    repeat (210) @(negedge clk);
    wait_cyc(120, w);
    check("shrink first cyc found", int'(w > 0), 1);
    repeat (79) @(negedge clk);
    ui_in  = 8'd20;
    uio_in = 8'hC0;
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'h00;
    wait_cyc(40, w);
`ifdef PWM_SHADOW_UPDATE_EN
    check("shrink edges to next cyc", w, 20);
`else
    check("shrink edges to next cyc", w, 2);
`endif
    highs   = 0;
    cyc_pos = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (uo_out[0]) highs++;
      if (uo_out[2] && cyc_pos < 0) cyc_pos = i;
    end
    check("shrink new period", cyc_pos, 20);
    check("shrink pwm highs", highs, 20);

    // Async reset in the middle of a high phase.
    do_reset();
    wr(1'b1, 10);
    wr(1'b0, 5);
    repeat (30) @(negedge clk);
    wait_cyc(30, w);
    check("pre-reset pwm high", int'(uo_out[0]), 1);
    #1 rst_n = 1'b0;
    #1 check("async reset uo_out", int'(uo_out), 2);
    @(negedge clk);
    rst_n = 1'b1;
    highs   = 0;
    cycs    = 0;
    bad_aux = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (uo_out[0]) highs++;
      if (uo_out[2]) cycs++;
      if (uo_out !== 8'h02) bad_aux++;
    end
    check("post-reset pwm highs", highs, 0);
    check("post-reset cyc pulses", cycs, 0);
    check("post-reset uo_out", bad_aux, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
